s2_combine: RTL and testbench
=============================

// Module: s2_combine
// PURPOSE
//  Stage-2 recombination stage of the hyperbolic CORDIC, downstream of the s2sinh/s2cosh shift-add
//  constant multipliers. Applies the addition formulas sinh(a+b)=sinh(a)cosh(b)+cosh(a)sinh(b) and
//  cosh(a+b)=cosh(a)cosh(b)+sinh(a)sinh(b) to the four pre-scaled terms. Elastic 2-deep pipeline
//  with valid/ready handshake; feeds the next CORDIC stage.
// PARAMETERS
//  DWIDTH  16  width of every data term; signed two's complement, same Q format on all ports
// PORTS
//  iClk      in   1       clock, all state on rising edge
//  iRst      in   1       asynchronous, active-high reset
//  iValid    in   1       upstream terms valid
//  oReady    out  1       stage can accept this cycle
//  iSinhAcB  in   DWIDTH  sinh(a)*cosh(b) term
//  iCoshAsB  in   DWIDTH  cosh(a)*sinh(b) term (s2sinh output on cosh(a))
//  iCoshAcB  in   DWIDTH  cosh(a)*cosh(b) term
//  iSinhAsB  in   DWIDTH  sinh(a)*sinh(b) term (s2sinh output on sinh(a))
//  iScomp    in   1       scomp side-band, carried unchanged alongside its data
//  oValid    out  1       result valid
//  iReady    in   1       downstream accepts
//  oSinh     out  DWIDTH  iSinhAcB + iCoshAsB
//  oCosh     out  DWIDTH  iCoshAcB + iSinhAsB
//  oScomp    out  1       iScomp of the result being presented
//  iClrOvf   in   1       synchronous clear of oOvf
//  oOvf      out  1       sticky: signed overflow seen in any accepted sum
//  oCount    out  2       results in flight (0..2)
// BEHAVIOUR
//  - Reset (async, iRst=1): s1/s2 valid=0, oValid=0, oOvf=0, oCount=0, oSinh=oCosh=0, oScomp=0.
//    A reset mid-operation discards in-flight data. No handshake occurs while iRst=1.
//  - S1: registers the four terms and iScomp on iValid&&oReady.
//  - S2: registers both sums, the side-band and per-sum overflow. Loads when S1 is valid and S2 is
//    empty or emptying.
//  - s2_adv = !s2_valid || iReady; s1_adv = !s1_valid || s2_adv; oReady = s1_adv.
//    The ready path is combinational; there is no skid buffer.
//  - Latency: 2 clocks, input accept edge to oValid. Throughput: 1 result/clk while iReady=1.
//  - Output hold: while oValid && !iReady, oSinh/oCosh/oScomp/oValid are stable.
//    Full state (S1 and S2 valid, iReady=0): oReady=0.
//  - Simultaneous accept and emit: when full and iReady=1, S2 takes S1 and S1 takes new input in the
//    same edge; no bubble, no loss.
//  - oCount = s1_valid + s2_valid.
//  - Arithmetic: DWIDTH-bit signed add. Overflow when both operands have the same sign and the sum
//    sign differs. Overflow is evaluated when the result loads into S2.
//  - oOvf sets on an overflow in either sum at S2 load and stays set until iClrOvf=1.
//    If iClrOvf and a new overflow occur in the same cycle, the set wins.
//  - No X may propagate to oValid/oReady/oCount. Data registers need not load while invalid.
// CONFIGURATION
//  - SAT_EN defined: an overflowing sum clamps to +max (0x7FFF for DWIDTH=16) when operands are
//    positive, or to -min (0x8000) when negative.
//  - SAT_EN undefined: sums wrap modulo 2^DWIDTH.
//  - oOvf behaviour is identical in both builds.
// TESTING (DWIDTH=16, iReady=1 unless stated)
//  1. Reset with iValid=1 held -> oValid=0, oReady=1, oCount=0. oReady is still 1 on the first
//     edge after reset release.
//  2. Single beat SinhAcB=0x1000, CoshAsB=0x0200, CoshAcB=0x4000, SinhAsB=0xFF00, iScomp=1
//     -> 2 clk later oSinh=0x1200, oCosh=0x3F00, oScomp=1, 1-cycle oValid pulse.
//  3. Back-to-back 8 beats -> 8 results on 8 consecutive cycles, in order, oCount settles at 2.
//  4. iReady=0 for 5 cycles mid-stream -> oReady=0 once oCount=2. Outputs are held, and when iReady
//     returns no beat is lost or duplicated (scoreboard).
//  5. SinhAcB=0x7000, CoshAsB=0x2000 -> oOvf=1 and oSinh=0x7FFF (SAT_EN) or 0x9000 (no SAT_EN).
//     With iClrOvf=1 for 1 clk, oOvf returns to 0.
//  6. Assert iRst for 1 clk while oCount=2 -> all outputs return to reset values at once. The next
//     accepted beat appears 2 clk after acceptance.

Source files
------------

// File: rtl/s2_combine.sv
// Stage-2 hyperbolic CORDIC recombination: sinh/cosh addition-formula sums behind a 2-deep valid/ready pipeline.
// Build option: define SAT_EN to clamp overflowing sums instead of wrapping.
module s2_combine #(
  parameter int DWIDTH = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DWIDTH-1:0] iSinhAcB,
  input  logic [DWIDTH-1:0] iCoshAsB,
  input  logic [DWIDTH-1:0] iCoshAcB,
  input  logic [DWIDTH-1:0] iSinhAsB,
  input  logic              iScomp,
  output logic              oValid,
  input  logic              iReady,
  output logic [DWIDTH-1:0] oSinh,
  output logic [DWIDTH-1:0] oCosh,
  output logic              oScomp,
  input  logic              iClrOvf,
  output logic              oOvf,
  output logic [1:0]        oCount
);

  // Signed add; returns {overflow, sum}. The sum wraps or clamps depending on SAT_EN.
  function automatic logic [DWIDTH:0] add_chk(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
    logic [DWIDTH-1:0] sum;
    logic              ovf;
    sum = a + b;
    ovf = (a[DWIDTH-1] == b[DWIDTH-1]) && (sum[DWIDTH-1] != a[DWIDTH-1]);
`ifdef SAT_EN
    if (ovf) begin
      sum = a[DWIDTH-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
    end else begin
      sum = sum;
    end
`endif
    return {ovf, sum};
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [DWIDTH-1:0] s1_sac_q, s1_sac_d;
  logic [DWIDTH-1:0] s1_cas_q, s1_cas_d;
  logic [DWIDTH-1:0] s1_cac_q, s1_cac_d;
  logic [DWIDTH-1:0] s1_sas_q, s1_sas_d;
  logic              s1_scomp_q, s1_scomp_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DWIDTH-1:0] sinh_q, sinh_d;
  logic [DWIDTH-1:0] cosh_q, cosh_d;
  logic              scomp_q, scomp_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        count_q, count_d;

  logic              s2_adv_s, s1_adv_s, accept_s, s2_load_s;
  logic [DWIDTH:0]   sinh_res_s, cosh_res_s;

  // Handshake: ready propagates combinationally back from the output stage.
  always_comb begin
    s2_adv_s  = !s2_valid_q || iReady;
    s1_adv_s  = !s1_valid_q || s2_adv_s;
    accept_s  = iValid && s1_adv_s;
    s2_load_s = s1_valid_q && s2_adv_s;
  end

  // Sums are formed from S1 and only matter when S2 loads.
  always_comb begin
    sinh_res_s = add_chk(s1_sac_q, s1_cas_q);
    cosh_res_s = add_chk(s1_cac_q, s1_sas_q);
  end

  // Next-state for both pipeline stages, sticky overflow and occupancy.
  always_comb begin
    s1_valid_d = s1_adv_s ? iValid : s1_valid_q;
    s1_sac_d   = s1_sac_q;
    s1_cas_d   = s1_cas_q;
    s1_cac_d   = s1_cac_q;
    s1_sas_d   = s1_sas_q;
    s1_scomp_d = s1_scomp_q;
    if (accept_s) begin
      s1_sac_d   = iSinhAcB;
      s1_cas_d   = iCoshAsB;
      s1_cac_d   = iCoshAcB;
      s1_sas_d   = iSinhAsB;
      s1_scomp_d = iScomp;
    end else begin
      s1_scomp_d = s1_scomp_q;
    end

    s2_valid_d = s2_adv_s ? s1_valid_q : s2_valid_q;
    sinh_d     = sinh_q;
    cosh_d     = cosh_q;
    scomp_d    = scomp_q;
    if (s2_load_s) begin
      sinh_d  = sinh_res_s[DWIDTH-1:0];
      cosh_d  = cosh_res_s[DWIDTH-1:0];
      scomp_d = s1_scomp_q;
    end else begin
      scomp_d = scomp_q;
    end

    // A new overflow takes priority over a clear in the same cycle.
    if (s2_load_s && (sinh_res_s[DWIDTH] || cosh_res_s[DWIDTH])) begin
      ovf_d = 1'b1;
    end else if (iClrOvf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    count_d = {1'b0, s1_valid_d} + {1'b0, s2_valid_d};
  end

  // Pipeline state registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s1_valid_q <= 1'b0;
      s1_sac_q   <= {DWIDTH{1'b0}};
      s1_cas_q   <= {DWIDTH{1'b0}};
      s1_cac_q   <= {DWIDTH{1'b0}};
      s1_sas_q   <= {DWIDTH{1'b0}};
      s1_scomp_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sinh_q     <= {DWIDTH{1'b0}};
      cosh_q     <= {DWIDTH{1'b0}};
      scomp_q    <= 1'b0;
      ovf_q      <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sac_q   <= s1_sac_d;
      s1_cas_q   <= s1_cas_d;
      s1_cac_q   <= s1_cac_d;
      s1_sas_q   <= s1_sas_d;
      s1_scomp_q <= s1_scomp_d;
      s2_valid_q <= s2_valid_d;
      sinh_q     <= sinh_d;
      cosh_q     <= cosh_d;
      scomp_q    <= scomp_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
    end
  end

  assign oReady = s1_adv_s;
  assign oValid = s2_valid_q;
  assign oSinh  = sinh_q;
  assign oCosh  = cosh_q;
  assign oScomp = scomp_q;
  assign oOvf   = ovf_q;
  assign oCount = count_q;

endmodule

// File: tb/tb_s2_combine.sv
// Directed self-checking bench for s2_combine (DWIDTH=16); expected values are hand-computed.
module tb_s2_combine;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [15:0] iSinhAcB = 16'h0000;
  logic [15:0] iCoshAsB = 16'h0000;
  logic [15:0] iCoshAcB = 16'h0000;
  logic [15:0] iSinhAsB = 16'h0000;
  logic        iScomp = 1'b0;
  logic        oValid;
  logic        iReady = 1'b1;
  logic [15:0] oSinh;
  logic [15:0] oCosh;
  logic        oScomp;
  logic        iClrOvf = 1'b0;
  logic        oOvf;
  logic [1:0]  oCount;

  int n_checks = 0;
  int n_fail   = 0;

  s2_combine #(.DWIDTH(16)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
    .iSinhAcB(iSinhAcB), .iCoshAsB(iCoshAsB), .iCoshAcB(iCoshAcB), .iSinhAsB(iSinhAsB),
    .iScomp(iScomp), .oValid(oValid), .iReady(iReady), .oSinh(oSinh), .oCosh(oCosh),
    .oScomp(oScomp), .iClrOvf(iClrOvf), .oOvf(oOvf), .oCount(oCount)
  );

  always #5 iClk = ~iClk;

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d, input logic sc);
    iValid = v; iSinhAcB = a; iCoshAsB = b; iCoshAcB = c; iSinhAsB = d; iScomp = sc;
  endtask

  task automatic step();
    @(posedge iClk);
    @(negedge iClk);
  endtask

  // Stream beat i: no overflow possible (cosh operands have opposite signs).
  function automatic logic [15:0] beat_a(input int i); return 16'(i * 256 + 17); endfunction
  function automatic logic [15:0] beat_b(input int i); return 16'(i * 16 + 1); endfunction
  function automatic logic [15:0] beat_c(input int i); return 16'h2000 + 16'(i); endfunction
  function automatic logic [15:0] beat_d(input int i); return 16'hFFF0 - 16'(i); endfunction

  task automatic test_reset();
    iRst = 1'b1;
    drive(1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    repeat (3) step();
    n_checks++;
    if (oValid !== 1'b0 || oReady !== 1'b1 || oCount !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: oValid=%b oReady=%b oCount=%0d, required 0/1/0", oValid, oReady, oCount);
    end
    iRst = 1'b0;
    step();
    n_checks++;
    if (oReady !== 1'b1 || oCount !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_release: oReady=%b oCount=%0d, required 1/1", oReady, oCount);
    end
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    repeat (3) step();
  endtask

  task automatic test_single();
    iReady = 1'b1;
    drive(1'b1, 16'h1000, 16'h0200, 16'h4000, 16'hFF00, 1'b1);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    n_checks++;
    if (oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: oValid=%b after 1 clk, required 0", oValid);
    end
    step();
    n_checks++;
    if (oValid !== 1'b1 || oSinh !== 16'h1200 || oCosh !== 16'h3F00 || oScomp !== 1'b1) begin
      n_fail++;
      $display("FAIL single_result: v=%b sinh=%h cosh=%h sc=%b, required 1/1200/3f00/1",
               oValid, oSinh, oCosh, oScomp);
    end
    step();
    n_checks++;
    if (oValid !== 1'b0 || oCount !== 2'd0) begin
      n_fail++;
      $display("FAIL single_pulse: oValid=%b oCount=%0d, required 0/0", oValid, oCount);
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int first = -1;
    int last = -1;
    iReady = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8) drive(1'b1, beat_a(cyc), beat_b(cyc), beat_c(cyc), beat_d(cyc), cyc[0]);
      else drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      #1;
      if (oValid === 1'b1) begin
        n_checks++;
        if (got >= 8 || oSinh !== beat_a(got) + beat_b(got) || oCosh !== beat_c(got) + beat_d(got)
            || oScomp !== got[0]) begin
          n_fail++;
          $display("FAIL b2b_data[%0d]: sinh=%h cosh=%h sc=%b, required %h/%h/%b", got, oSinh, oCosh,
                   oScomp, beat_a(got) + beat_b(got), beat_c(got) + beat_d(got), got[0]);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (cyc == 5) begin
        n_checks++;
        if (oCount !== 2'd2) begin
          n_fail++;
          $display("FAIL b2b_count: oCount=%0d, required 2", oCount);
        end
      end
      step();
    end
    n_checks++;
    if (got !== 8 || first !== 2 || last - first !== 7) begin
      n_fail++;
      $display("FAIL b2b_timing: got=%0d first=%0d last=%0d, required 8/2/9", got, first, last);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int got = 0;
    logic stalled_prev = 1'b0;
    logic [15:0] hold_s = 16'h0000;
    logic [15:0] hold_c = 16'h0000;
    logic hold_sc = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      iReady = !(cyc >= 3 && cyc < 8);
      if (idx < 10) drive(1'b1, beat_a(idx), beat_b(idx), beat_c(idx), beat_d(idx), idx[0]);
      else drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      #1;
      if (stalled_prev) begin
        n_checks++;
        if (oValid !== 1'b1 || oSinh !== hold_s || oCosh !== hold_c || oScomp !== hold_sc) begin
          n_fail++;
          $display("FAIL bp_hold: v=%b sinh=%h cosh=%h sc=%b, required 1/%h/%h/%b",
                   oValid, oSinh, oCosh, oScomp, hold_s, hold_c, hold_sc);
        end
      end
      if (cyc == 6) begin
        n_checks++;
        if (oCount !== 2'd2 || oReady !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_full: oCount=%0d oReady=%b, required 2/0", oCount, oReady);
        end
      end
      if (oValid === 1'b1 && iReady) begin
        n_checks++;
        if (got >= 10 || oSinh !== beat_a(got) + beat_b(got) || oCosh !== beat_c(got) + beat_d(got)
            || oScomp !== got[0]) begin
          n_fail++;
          $display("FAIL bp_data[%0d]: sinh=%h cosh=%h sc=%b, required %h/%h/%b", got, oSinh, oCosh,
                   oScomp, beat_a(got) + beat_b(got), beat_c(got) + beat_d(got), got[0]);
        end
        got++;
      end
      stalled_prev = (oValid === 1'b1) && !iReady;
      hold_s = oSinh; hold_c = oCosh; hold_sc = oScomp;
      if (iValid && oReady === 1'b1) idx++;
      step();
    end
    iReady = 1'b1;
    n_checks++;
    if (got !== 10 || idx !== 10 || oCount !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_total: got=%0d sent=%0d oCount=%0d, required 10/10/0", got, idx, oCount);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_s;
    logic [15:0] exp_c;
`ifdef SAT_EN
    exp_s = 16'h7FFF; exp_c = 16'h8000;
`else
    exp_s = 16'h9000; exp_c = 16'h7FFF;
`endif
    iReady = 1'b1;
    drive(1'b1, 16'h7000, 16'h2000, 16'h8000, 16'hFFFF, 1'b0);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    n_checks++;
    if (oOvf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_early: oOvf=%b before S2 load, required 0", oOvf);
    end
    step();
    n_checks++;
    if (oValid !== 1'b1 || oOvf !== 1'b1 || oSinh !== exp_s || oCosh !== exp_c) begin
      n_fail++;
      $display("FAIL ovf_result: v=%b ovf=%b sinh=%h cosh=%h, required 1/1/%h/%h",
               oValid, oOvf, oSinh, oCosh, exp_s, exp_c);
    end
    repeat (2) step();
    n_checks++;
    if (oOvf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: oOvf=%b, required 1", oOvf);
    end
    iClrOvf = 1'b1;
    step();
    iClrOvf = 1'b0;
    n_checks++;
    if (oOvf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: oOvf=%b, required 0", oOvf);
    end
    drive(1'b1, 16'h7000, 16'h2000, 16'h0001, 16'h0001, 1'b0);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    iClrOvf = 1'b1;
    step();
    n_checks++;
    if (oOvf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: oOvf=%b, required 1", oOvf);
    end
    step();
    iClrOvf = 1'b0;
    n_checks++;
    if (oOvf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear2: oOvf=%b, required 0", oOvf);
    end
  endtask

  task automatic test_reset_midstream();
    iReady = 1'b0;
    drive(1'b1, 16'h7000, 16'h2000, 16'h0000, 16'h0000, 1'b1);
    step();
    drive(1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    n_checks++;
    if (oCount !== 2'd2 || oReady !== 1'b0 || oOvf !== 1'b1 || oValid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_fill: cnt=%0d rdy=%b ovf=%b v=%b, required 2/0/1/1", oCount, oReady, oOvf, oValid);
    end
    iRst = 1'b1;
    #1;
    n_checks++;
    if (oValid !== 1'b0 || oCount !== 2'd0 || oSinh !== 16'h0000 || oCosh !== 16'h0000
        || oScomp !== 1'b0 || oOvf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: v=%b cnt=%0d sinh=%h cosh=%h sc=%b ovf=%b, required all 0",
               oValid, oCount, oSinh, oCosh, oScomp, oOvf);
    end
    step();
    iRst = 1'b0;
    iReady = 1'b1;
    drive(1'b1, 16'h1000, 16'h0200, 16'h4000, 16'hFF00, 1'b1);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    n_checks++;
    if (oValid !== 1'b0 || oCount !== 2'd1) begin
      n_fail++;
      $display("FAIL rst_mid_lat1: v=%b cnt=%0d, required 0/1", oValid, oCount);
    end
    step();
    n_checks++;
    if (oValid !== 1'b1 || oSinh !== 16'h1200 || oCosh !== 16'h3F00 || oScomp !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_beat: v=%b sinh=%h cosh=%h sc=%b, required 1/1200/3f00/1",
               oValid, oSinh, oCosh, oScomp);
    end
    step();
  endtask

  initial begin
    @(negedge iClk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
